mem_read_sequencer: RTL and testbench

Control FSM for the 4-byte memory read datapath: accepts a word-read request from the requester, drives the datapath's address-load, counter-reset, byte-load and counter-increment strobes, and handshakes each byte with an 8-bit memory through a read strobe, a programmable wait-state count and a ready input. It pulses `ready` when the assembled 32-bit word on the datapath's `databus32` is valid, and pulses `err` if memory fails to respond within a timeout.

---
 rtl/mem_read_sequencer_if.sv | 28 ++
 rtl/mem_read_sequencer.sv | 132 +++++++++++++
 tb/tb_mem_read_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_read_sequencer_if: requester/memory handshake and datapath     |
// | strobes of the word-read sequencer.            Revision: 1.0       |
// +--------------------------------------------------------------------+
interface mem_read_sequencer_if;
  logic req;
  logic memrdy;
  logic ldaddr;
  logic rst2;
  logic memrd;
  logic ldden;
  logic incc2;
  logic ready;
  logic err;
  logic busy;

  modport master (
    input  req, memrdy,
    output ldaddr, rst2, memrd, ldden, incc2, ready, err, busy
  );

  modport slave (
    output req, memrdy,
    input  ldaddr, rst2, memrd, ldden, incc2, ready, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_read_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_read_sequencer: Moore FSM sequencing four byte reads from an   |
// | 8-bit memory into the 32-bit datapath.         Revision: 1.0       |
// +--------------------------------------------------------------------+
module mem_read_sequencer #(
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_read_sequencer_if.master   bus
);

  localparam logic [3:0] c_wait_max = 4'(WAIT_CYCLES);
  localparam logic [7:0] c_timeout  = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_CAPT = 3'd3,
    ST_NEXT = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_bidx;
  logic [3:0] r_wcnt;
  logic [7:0] r_tcnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bidx <= 2'd0;
      r_wcnt <= 4'd0;
      r_tcnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req) begin
            r_bidx <= 2'd0;
          end
        end
        ST_LOAD: begin
          r_wcnt <= 4'd0;
          r_tcnt <= 8'd0;
        end
        ST_WAIT: begin
          if (r_wcnt != c_wait_max) begin
            r_wcnt <= r_wcnt + 4'd1;
          end
          r_tcnt <= r_tcnt + 8'd1;
        end
        ST_NEXT: begin
          if (r_bidx != 2'd3) begin
            r_bidx <= r_bidx + 2'd1;
            r_wcnt <= 4'd0;
            r_tcnt <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs depend on r_state only; inputs steer the next state alone.
  always_comb begin
    w_next     = r_state;
    bus.ldaddr = 1'b0;
    bus.rst2   = 1'b0;
    bus.memrd  = 1'b0;
    bus.ldden  = 1'b0;
    bus.incc2  = 1'b0;
    bus.ready  = 1'b0;
    bus.err    = 1'b0;
    bus.busy   = 1'b1;
    case (r_state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.req) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bus.ldaddr = 1'b1;
        bus.rst2   = 1'b1;
        w_next     = ST_WAIT;
      end
      ST_WAIT: begin
        bus.memrd = 1'b1;
        if ((r_wcnt == c_wait_max) && bus.memrdy) begin
          w_next = ST_CAPT;
        end else if (r_tcnt == c_timeout) begin
          w_next = ST_ERR;
        end
      end
      ST_CAPT: begin
        bus.memrd = 1'b1;
        bus.ldden = 1'b1;
        w_next    = ST_NEXT;
      end
      ST_NEXT: begin
        bus.incc2 = 1'b1;
        w_next    = (r_bidx == 2'd3) ? ST_DONE : ST_WAIT;
      end
      ST_DONE: begin
        bus.ready = 1'b1;
        w_next    = ST_IDLE;
      end
      ST_ERR: begin
        bus.err = 1'b1;
        w_next  = ST_IDLE;
      end
      default: begin
        bus.busy = 1'b0;
        w_next   = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_read_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_read_sequencer: two sequencer instances (W=2/T=15, W=0/T=5) |
// | against a schedule-level model.                Revision: 1.0       |
// +--------------------------------------------------------------------+
module tb_mem_read_sequencer;

  localparam int N  = 2000;
  localparam int SZ = 2400;
  localparam int A  = 4;
  localparam int B  = 30;
  localparam int C  = 60;
  localparam int D  = 82;
  localparam int E  = 120;
  localparam int F  = 158;
  localparam int R0 = 210;

  localparam logic [7:0] B_LDADDR = 8'h01;
  localparam logic [7:0] B_RST2   = 8'h02;
  localparam logic [7:0] B_MEMRD  = 8'h04;
  localparam logic [7:0] B_LDDEN  = 8'h08;
  localparam logic [7:0] B_INCC2  = 8'h10;
  localparam logic [7:0] B_READY  = 8'h20;
  localparam logic [7:0] B_ERR    = 8'h40;
  localparam logic [7:0] B_BUSY   = 8'h80;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] addr_in;

  always #5 clk = ~clk;

  mem_read_sequencer_if bus0 ();
  mem_read_sequencer_if bus1 ();

  mem_read_sequencer #(.WAIT_CYCLES(2), .TIMEOUT(15)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mem_read_sequencer #(.WAIT_CYCLES(0), .TIMEOUT(5))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  bit         rstn_a   [SZ];
  bit         req_a    [SZ];
  bit         memrdy_a [SZ];
  logic [7:0] addr_a   [SZ];
  logic [7:0] mem      [256];
  logic [7:0] exp_out  [2][SZ];
  logic [31:0] exp_word [2][SZ];

  int n_tests = 0;
  int n_fail  = 0;

  // External 4-byte datapath fed by each sequencer's strobes.
  logic [7:0] dp_addr0, dp_addr1;
  logic [1:0] dp_cnt0, dp_cnt1;
  logic [7:0] dp_reg0 [4];
  logic [7:0] dp_reg1 [4];
  logic [31:0] word0, word1;
  logic [7:0]  out0, out1;

  always @(posedge clk) begin
    if (bus0.ldaddr) dp_addr0 <= addr_in;
    if (bus0.rst2) dp_cnt0 <= 2'd0;
    else if (bus0.incc2) dp_cnt0 <= dp_cnt0 + 2'd1;
    if (bus0.ldden) dp_reg0[dp_cnt0] <= mem[8'(dp_addr0 + 8'(dp_cnt0))];
  end

  always @(posedge clk) begin
    if (bus1.ldaddr) dp_addr1 <= addr_in;
    if (bus1.rst2) dp_cnt1 <= 2'd0;
    else if (bus1.incc2) dp_cnt1 <= dp_cnt1 + 2'd1;
    if (bus1.ldden) dp_reg1[dp_cnt1] <= mem[8'(dp_addr1 + 8'(dp_cnt1))];
  end

  assign word0 = {dp_reg0[3], dp_reg0[2], dp_reg0[1], dp_reg0[0]};
  assign word1 = {dp_reg1[3], dp_reg1[2], dp_reg1[1], dp_reg1[0]};
  assign out0  = {bus0.busy, bus0.err, bus0.ready, bus0.incc2, bus0.ldden, bus0.memrd, bus0.rst2, bus0.ldaddr};
  assign out1  = {bus1.busy, bus1.err, bus1.ready, bus1.incc2, bus1.ldden, bus1.memrd, bus1.rst2, bus1.ldaddr};

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Transaction schedule: walk idle cycles, place LOAD, then for each byte find
  // the first WAIT cycle index k in [w, t] with memrdy, else time out at k == t.
  task automatic build_model(input int k, input int w, input int t);
    int c, s, load;
    bit aborted;
    logic [7:0] a;
    for (int i = 0; i < SZ; i++) begin
      exp_out[k][i]  = 8'h00;
      exp_word[k][i] = 32'h0;
    end
    c = 0;
    while (c < N) begin
      if (!rstn_a[c] || !req_a[c]) begin
        c++;
        continue;
      end
      load = c + 1;
      exp_out[k][load] = B_LDADDR | B_RST2 | B_BUSY;
      c = load + 1;
      if (!rstn_a[load]) continue;
      aborted = 1'b0;
      for (int b = 0; b < 4 && !aborted; b++) begin
        s = c;
        for (int j = s; j <= s + t; j++) begin
          exp_out[k][j] = B_MEMRD | B_BUSY;
          if (!rstn_a[j]) begin
            aborted = 1'b1;
            c = j + 1;
            break;
          end
          if ((j - s >= w) && memrdy_a[j]) begin
            exp_out[k][j+1] = B_MEMRD | B_LDDEN | B_BUSY;
            if (!rstn_a[j+1]) begin
              aborted = 1'b1;
              c = j + 2;
              break;
            end
            exp_out[k][j+2] = B_INCC2 | B_BUSY;
            if (!rstn_a[j+2]) aborted = 1'b1;
            c = j + 3;
            break;
          end
          if (j - s == t) begin
            exp_out[k][j+1] = B_ERR | B_BUSY;
            aborted = 1'b1;
            c = j + 2;
            break;
          end
        end
      end
      if (!aborted) begin
        a = addr_a[load];
        exp_out[k][c]  = B_READY | B_BUSY;
        exp_word[k][c] = {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
        c++;
      end
    end
  endtask

  initial begin
    int burst;
    rst = 1'b0;
    addr_in = 8'h00;
    bus0.req = 1'b0; bus0.memrdy = 1'b0;
    bus1.req = 1'b0; bus1.memrdy = 1'b0;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    for (int i = 0; i < SZ; i++) begin
      rstn_a[i] = 1'b1; req_a[i] = 1'b0; memrdy_a[i] = 1'b1; addr_a[i] = 8'($urandom);
    end
    rstn_a[0] = 1'b0; rstn_a[1] = 1'b0;
    req_a[A] = 1'b1; addr_a[A+1] = 8'h00;
    req_a[B] = 1'b1;
    for (int i = 12; i <= 18; i++) memrdy_a[B+i] = 1'b0;
    req_a[C] = 1'b1;
    for (int i = 1; i <= 20; i++) memrdy_a[C+i] = 1'b0;
    req_a[D] = 1'b1;
    for (int i = 2; i <= 16; i++) memrdy_a[D+i] = 1'b0;
    req_a[E] = 1'b1; rstn_a[E+8] = 1'b0; req_a[E+12] = 1'b1;
    req_a[F] = 1'b1; req_a[F+6] = 1'b1; req_a[F+23] = 1'b1;
    burst = 0;
    for (int i = R0; i < SZ; i++) begin
      if (burst > 0) begin
        memrdy_a[i] = 1'b0;
        burst--;
      end else begin
        if ($urandom % 60 == 0) burst = int'($urandom_range(8, 25));
        memrdy_a[i] = ($urandom % 3 != 0);
      end
      req_a[i]  = ($urandom % 9 == 0);
      rstn_a[i] = ($urandom % 250 != 0);
    end

    build_model(0, 2, 15);
    build_model(1, 0, 5);

    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      rst = rstn_a[c];
      bus0.req = req_a[c];    bus1.req = req_a[c];
      bus0.memrdy = memrdy_a[c]; bus1.memrdy = memrdy_a[c];
      addr_in = addr_a[c];
      @(negedge clk);
      chk("outs_w2", c, 32'(out0), 32'(exp_out[0][c]));
      chk("outs_w0", c, 32'(out1), 32'(exp_out[1][c]));
      if ((exp_out[0][c] & B_READY) != 8'h00) chk("word_w2", c, word0, exp_word[0][c]);
      if ((exp_out[1][c] & B_READY) != 8'h00) chk("word_w0", c, word1, exp_word[1][c]);
      if (c == 0)      chk("reset_idle", c, 32'(out0), 32'h0);
      if (c == A + 1)  chk("nom_load", c, 32'({bus0.ldaddr, bus0.rst2}), 32'h3);
      if (c == A + 2)  chk("nom_load_once", c, 32'({bus0.ldaddr, bus0.rst2}), 32'h0);
      if (c == A + 21) chk("nom_not_early", c, 32'(bus0.ready), 32'h0);
      if (c == A + 22) chk("nom_ready_c22", c, 32'(bus0.ready), 32'h1);
      if (c == A + 22) chk("nom_word", c, word0, 32'h44332211);
      if (c == A + 14) chk("w0_ready_c14", c, 32'(bus1.ready), 32'h1);
      if (c == A + 14) chk("w0_word", c, word1, 32'h44332211);
      if (c == B + 27) chk("slow_ready_c27", c, 32'(bus0.ready), 32'h1);
      if (c == C + 18) chk("timeout_err_c18", c, 32'({bus0.err, bus0.ready}), 32'h2);
      if (c == C + 19) chk("timeout_idle", c, 32'(bus0.busy), 32'h0);
      if (c == D + 18) chk("tie_capt", c, 32'({bus0.err, bus0.ldden}), 32'h1);
      if (c == D + 35) chk("tie_ready", c, 32'(bus0.ready), 32'h1);
      if (c == E + 9)  chk("midreset_zero", c, 32'(out0), 32'h0);
      if (c == E + 34) chk("midreset_restart", c, 32'(bus0.ready), 32'h1);
      if (c == F + 22) chk("b2b_ready1", c, 32'(bus0.ready), 32'h1);
      if (c == F + 24) chk("b2b_load", c, 32'(bus0.ldaddr), 32'h1);
      if (c == F + 28) chk("busy_req_dropped", c, 32'(bus0.ready), 32'h0);
      if (c == F + 45) chk("b2b_ready2", c, 32'(bus0.ready), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
